// File: rtl/core101_pkg.sv
// Shared core constants and the fetch FSM state encoding.
package core101_pkg;

    localparam int                XLEN       = 32;
    localparam logic [XLEN-1:0]   RESET_ADDR = 32'h0000_0000;
    localparam int                INS_BYTES  = 4;

    // Fetch FSM: REQ issues normally, DROP waits out a request made stale by a redirect.
    typedef enum logic [0:0] {
        FETCH_REQ  = 1'b0,
        FETCH_DROP = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instruction} entries between the memory port and decode.
// The head word is held in a register so decode sees registered outputs; while the
// FIFO is empty the head register keeps the last delivered entry.
module fetch_buffer #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             head_valid_r;
    logic [WIDTH-1:0] head_data_r, head_data_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Circular pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state of storage, pointers, count and the head register.
    always_comb begin
        mem_s     = mem_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        cnt_s     = cnt_r;
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
            cnt_s    = {CNT_W{1'b0}};
        end else begin
            do_pop_s  = pop && (cnt_r != {CNT_W{1'b0}});
            do_push_s = push && ((cnt_r < CNT_W'(DEPTH)) || do_pop_s);
            if (do_push_s) begin
                mem_s[wr_ptr_r] = push_data;
                wr_ptr_s        = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (do_push_s && !do_pop_s) begin
                cnt_s = cnt_r + CNT_W'(1);
            end else if (!do_push_s && do_pop_s) begin
                cnt_s = cnt_r - CNT_W'(1);
            end else begin
                cnt_s = cnt_r;
            end
        end
        if (cnt_s != {CNT_W{1'b0}}) begin
            head_data_s = mem_s[rd_ptr_s];
        end else begin
            head_data_s = head_data_r;
        end
    end

    // FIFO state and registered head outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            head_valid_r <= 1'b0;
            head_data_r  <= {WIDTH{1'b0}};
        end else begin
            mem_r        <= mem_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            cnt_r        <= cnt_s;
            head_valid_r <= (cnt_s != {CNT_W{1'b0}});
            head_data_r  <= head_data_s;
        end
    end

    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;
    assign count      = cnt_r;

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: initiator on the instruction-memory valid/ready port,
// PC sequencing with redirects, and a small buffer feeding decode.
module ins_fetch_unit #(
    parameter int              XLEN       = core101_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_ADDR = core101_pkg::RESET_ADDR,
    parameter int              BUF_DEPTH  = 2
) (
    input  logic            clock_in,
    input  logic            reset_n_in,
    output logic            ins_mem_valid_out,
    output logic [XLEN-1:0] ins_mem_addr_out,
    input  logic            ins_mem_ready_in,
    input  logic [XLEN-1:0] ins_mem_data_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_addr_in,
    output logic            fetch_valid_out,
    output logic [XLEN-1:0] fetch_ins_out,
    output logic [XLEN-1:0] fetch_pc_out,
    input  logic            fetch_ready_in
);

    import core101_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e        state_r, state_s;
    logic                mem_valid_r, mem_valid_s;
    logic [XLEN-1:0]     mem_addr_r, mem_addr_s;
    logic [XLEN-1:0]     pend_addr_r, pend_addr_s;
    logic [XLEN-1:0]     redir_addr_s;
    logic                xfer_s;
    logic                push_s;
    logic                pop_s;
    logic                flush_s;
    logic                buf_valid_s;
    logic [2*XLEN-1:0]   buf_data_s;
    logic [CNT_W-1:0]    buf_count_s;
    logic [CNT_W:0]      cnt_after_s;
    logic                slot_free_s;

    // A transfer happens whenever our request meets ready; data is valid that cycle.
    assign xfer_s       = mem_valid_r & ins_mem_ready_in;
    assign pop_s        = buf_valid_s & fetch_ready_in;
    // A redirect empties the buffer; in DROP it is already empty so this is harmless.
    assign flush_s      = redirect_valid_in;
    // Only transfers in normal issue with no redirect carry live instructions.
    assign push_s       = xfer_s & ~redirect_valid_in & (state_r == FETCH_REQ);
    assign redir_addr_s = {redirect_addr_in[XLEN-1:2], 2'b00};

    // Buffer occupancy as it will be after this edge, for the slot-guarantee issue rule.
    always_comb begin
        if (flush_s) begin
            cnt_after_s = {(CNT_W+1){1'b0}};
        end else if (push_s && !pop_s) begin
            cnt_after_s = {1'b0, buf_count_s} + (CNT_W+1)'(1);
        end else if (!push_s && pop_s) begin
            cnt_after_s = {1'b0, buf_count_s} - (CNT_W+1)'(1);
        end else begin
            cnt_after_s = {1'b0, buf_count_s};
        end
        slot_free_s = (cnt_after_s < (CNT_W+1)'(BUF_DEPTH));
    end

    // FSM state register.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_r <= FETCH_REQ;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: a redirect that catches a stalled request must wait it out in DROP.
    always_comb begin
        case (state_r)
            FETCH_REQ: begin
                if (redirect_valid_in && mem_valid_r && !ins_mem_ready_in) begin
                    state_s = FETCH_DROP;
                end else begin
                    state_s = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                if (ins_mem_ready_in) begin
                    state_s = FETCH_REQ;
                end else begin
                    state_s = FETCH_DROP;
                end
            end
            default: state_s = FETCH_REQ;
        endcase
    end

    // FSM outputs: next request valid/address and pending redirect target.
    always_comb begin
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        pend_addr_s = pend_addr_r;
        case (state_r)
            FETCH_REQ: begin
                if (redirect_valid_in) begin
                    if (mem_valid_r && !ins_mem_ready_in) begin
                        // Request must stay stable; remember where to go afterwards.
                        pend_addr_s = redir_addr_s;
                    end else begin
                        mem_addr_s  = redir_addr_s;
                        mem_valid_s = slot_free_s;
                    end
                end else begin
                    if (xfer_s) begin
                        mem_addr_s = mem_addr_r + XLEN'(INS_BYTES);
                    end else begin
                        mem_addr_s = mem_addr_r;
                    end
                    if (!mem_valid_r || xfer_s) begin
                        mem_valid_s = slot_free_s;
                    end else begin
                        mem_valid_s = 1'b1;
                    end
                end
            end
            FETCH_DROP: begin
                if (redirect_valid_in) begin
                    pend_addr_s = redir_addr_s;
                end else begin
                    pend_addr_s = pend_addr_r;
                end
                if (ins_mem_ready_in) begin
                    mem_addr_s  = redirect_valid_in ? redir_addr_s : pend_addr_r;
                    mem_valid_s = slot_free_s;
                end else begin
                    mem_valid_s = 1'b1;
                end
            end
            default: begin
                mem_valid_s = 1'b0;
            end
        endcase
    end

    // Request-side registers.
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            mem_valid_r <= 1'b0;
            mem_addr_r  <= RESET_ADDR;
            pend_addr_r <= {XLEN{1'b0}};
        end else begin
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            pend_addr_r <= pend_addr_s;
        end
    end

    fetch_buffer #(
        .WIDTH (2 * XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clock_in),
        .rst_n      (reset_n_in),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  ({mem_addr_r, ins_mem_data_in}),
        .pop        (pop_s),
        .head_valid (buf_valid_s),
        .head_data  (buf_data_s),
        .count      (buf_count_s)
    );

    assign ins_mem_valid_out = mem_valid_r;
    assign ins_mem_addr_out  = mem_addr_r;
    assign fetch_valid_out   = buf_valid_s;
    assign fetch_pc_out      = buf_data_s[2*XLEN-1:XLEN];
    assign fetch_ins_out     = buf_data_s[XLEN-1:0];

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_ins_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk;
    logic            rst_n;
    logic            ready;
    logic            redir_v;
    logic [XLEN-1:0] redir_a;
    logic            fready;

    logic            m_valid, m2_valid;
    logic [XLEN-1:0] m_addr, m2_addr;
    logic [XLEN-1:0] m_data, m2_data;
    logic            f_valid, f2_valid;
    logic [XLEN-1:0] f_ins, f2_ins, f_pc, f2_pc;

    int n_checks;
    int n_errors;
    bit cmp_en;

    // reference model state
    bit              md_req;
    bit              md_drop;
    logic [XLEN-1:0] md_addr;
    logic [XLEN-1:0] md_pend;
    logic [63:0]     md_q[$];
    logic [XLEN-1:0] md_hpc;
    logic [XLEN-1:0] md_hins;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    assign m_data  = mem_word(m_addr);
    assign m2_data = mem_word(m2_addr);

    ins_fetch_unit #(.XLEN(XLEN), .RESET_ADDR(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clock_in(clk), .reset_n_in(rst_n),
        .ins_mem_valid_out(m_valid), .ins_mem_addr_out(m_addr),
        .ins_mem_ready_in(ready), .ins_mem_data_in(m_data),
        .redirect_valid_in(redir_v), .redirect_addr_in(redir_a),
        .fetch_valid_out(f_valid), .fetch_ins_out(f_ins), .fetch_pc_out(f_pc),
        .fetch_ready_in(fready)
    );

    ins_fetch_unit #(.XLEN(XLEN), .RESET_ADDR(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) dut2 (
        .clock_in(clk), .reset_n_in(rst_n),
        .ins_mem_valid_out(m2_valid), .ins_mem_addr_out(m2_addr),
        .ins_mem_ready_in(ready), .ins_mem_data_in(m2_data),
        .redirect_valid_in(redir_v), .redirect_addr_in(redir_a),
        .fetch_valid_out(f2_valid), .fetch_ins_out(f2_ins), .fetch_pc_out(f2_pc),
        .fetch_ready_in(fready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, computed with a queue as the buffer.
    task automatic model_step();
        bit          xfer;
        bit          pop;
        logic [31:0] ra;
        if (!rst_n) begin
            md_req = 0; md_drop = 0; md_addr = 32'h0; md_pend = 32'h0;
            md_q.delete(); md_hpc = 32'h0; md_hins = 32'h0;
        end else begin
            xfer = md_req && ready;
            pop  = (md_q.size() != 0) && fready;
            ra   = {redir_a[31:2], 2'b00};
            if (redir_v) begin
                md_q.delete();
                if (md_drop) begin
                    md_pend = ra;
                    if (ready) begin md_addr = ra; md_drop = 0; end
                end else if (md_req && !ready) begin
                    md_drop = 1; md_pend = ra;
                end else begin
                    md_addr = ra; md_req = 1;
                end
            end else if (md_drop) begin
                if (ready) begin md_addr = md_pend; md_drop = 0; end
            end else begin
                if (pop) void'(md_q.pop_front());
                if (xfer) begin
                    md_q.push_back({md_addr, mem_word(md_addr)});
                    md_addr = md_addr + 32'd4;
                end
                if (!md_req || xfer) md_req = (md_q.size() < DEPTH);
            end
            if (md_q.size() != 0) {md_hpc, md_hins} = md_q[0];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare DUT against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_valid", {63'd0, m_valid}, {63'd0, md_req});
                chk("m_addr",  {32'd0, m_addr},  {32'd0, md_addr});
                chk("f_valid", {63'd0, f_valid}, {63'd0, (md_q.size() != 0)});
                chk("f_pc",    {32'd0, f_pc},    {32'd0, md_hpc});
                chk("f_ins",   {32'd0, f_ins},   {32'd0, md_hins});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, {32'd0, act}, {32'd0, exp});
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cmp_en = 0;
        rst_n = 1'b0; ready = 1'b1; fready = 1'b1; redir_v = 1'b0; redir_a = 32'h0;
        step(); step();
        cmp_en = 1;
        lit("rst_valid", {31'd0, m_valid}, 32'd0);
        lit("rst_addr", m_addr, 32'h0);
        lit("rst_fvalid", {31'd0, f_valid}, 32'd0);
        lit("rst_fpc", f_pc, 32'h0);
        lit("rst_fins", f_ins, 32'h0);
        lit("rst_addr2", m2_addr, 32'hFFFF_FFFC);
        lit("rst_f2", {f2_valid, f2_pc[30:0]} | f2_ins, 32'h0);

        // streaming from reset
        rst_n = 1'b1;
        step();
        lit("s1_valid", {31'd0, m_valid}, 32'd1);
        lit("s1_addr", m_addr, 32'h0);
        lit("s1_addr2", m2_addr, 32'hFFFF_FFFC);
        step();
        lit("s2_addr", m_addr, 32'h4);
        lit("s2_fpc", f_pc, 32'h0);
        lit("s2_fins", f_ins, 32'h5A5A_C3C3);
        lit("s2_addr2_wrap", m2_addr, 32'h0);
        step();
        lit("s3_addr", m_addr, 32'h8);
        lit("s3_fpc", f_pc, 32'h4);

        // memory stall: request held stable
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            lit("stall_valid", {31'd0, m_valid}, 32'd1);
            lit("stall_addr", m_addr, 32'h8);
        end
        ready = 1'b1;
        step();
        lit("stall_done_fpc", f_pc, 32'h8);
        lit("stall_done_addr", m_addr, 32'hC);
        ready = 1'b0;
        step();
        lit("single_push", {31'd0, f_valid}, 32'd0);

        // decode stall: buffer fills, issue stops, then resumes
        fready = 1'b0; ready = 1'b1;
        step(); step();
        lit("full_valid", {31'd0, m_valid}, 32'd0);
        lit("full_addr", m_addr, 32'h14);
        step();
        lit("full_hold", {31'd0, m_valid}, 32'd0);
        lit("full_fpc", f_pc, 32'hC);
        fready = 1'b1;
        step();
        lit("resume_addr", m_addr, 32'h14);
        lit("resume_valid", {31'd0, m_valid}, 32'd1);
        lit("resume_fpc", f_pc, 32'h10);
        step();
        lit("resume_fpc2", f_pc, 32'h14);

        // redirect while a request is stalled
        ready = 1'b0;
        step();
        redir_v = 1'b1; redir_a = 32'h103;
        step();
        redir_v = 1'b0;
        lit("drop_addr", m_addr, 32'h18);
        step();
        lit("drop_hold", m_addr, 32'h18);
        ready = 1'b1;
        step();
        lit("drop_new_addr", m_addr, 32'h100);
        lit("drop_fvalid", {31'd0, f_valid}, 32'd0);
        step();
        lit("drop_first_pc", f_pc, 32'h100);

        // redirect with ready and a pending pop in the same cycle
        redir_v = 1'b1; redir_a = 32'h200;
        step();
        redir_v = 1'b0;
        lit("redir_flush", {31'd0, f_valid}, 32'd0);
        lit("redir_addr", m_addr, 32'h200);
        step();
        lit("redir_fpc", f_pc, 32'h200);

        // second redirect overwrites the pending target
        ready = 1'b0;
        step();
        redir_v = 1'b1; redir_a = 32'h300;
        step();
        redir_a = 32'h404;
        step();
        redir_v = 1'b0; ready = 1'b1;
        step();
        lit("redir2_addr", m_addr, 32'h404);
        step();
        lit("redir2_fins", f_ins, mem_word(32'h404));

        // mixed traffic, model-checked
        for (int i = 0; i < 48; i++) begin
            ready   = (i % 3) != 2;
            fready  = ((i % 5) != 4) && ((i % 7) != 0);
            redir_v = (i % 11) == 10;
            redir_a = 32'h1000 + 32'(i) * 32'h40 + 32'(i % 4);
            step();
        end
        redir_v = 1'b0;

        // reset in the middle of a request
        ready = 1'b0; fready = 1'b1;
        step(); step();
        rst_n = 1'b0;
        step();
        lit("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        lit("mid_rst_addr", m_addr, 32'h0);
        lit("mid_rst_fvalid", {31'd0, f_valid}, 32'd0);
        rst_n = 1'b1; ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
